q16_to_bcd: RTL
===============

# q16_to_bcd

Sequential converter consuming the divider's Q16.16 result and status flags and producing sign-magnitude BCD digits for the calculator display path. It sits directly downstream of the divider: `start` is driven by the divider's `done`, and `val`, `in_dbz` and `in_ovf` come from the divider's `val`, `dbz` and `ovf`. Integer digits use a shift-add-3 (double-dabble) loop. Fraction digits use repeated multiply-by-10 on the fractional bits, and both run in the same iteration window.

## Interface
- `WIDTH`, 32: total bits of the Q16.16 input.
- `FBITS`, 16: fractional bits; integer part is `WIDTH-FBITS` = 16 bits.
- `IDIG`, 5: integer BCD digits; must hold 32768.
- `FDIG`, 4: fraction BCD digits; must satisfy `FDIG` ≤ `WIDTH-FBITS`-1.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; samples `val`, `in_dbz`, `in_ovf`.
- `val`  in  WIDTH  signed Q16.16 value.
- `in_dbz`  in  1  upstream divide-by-zero flag.
- `in_ovf`  in  1  upstream overflow flag.
- `busy`  out  1  high while converting.
- `done`  out  1  one-cycle completion pulse.
- `neg`  out  1  display minus sign.
- `int_bcd`  out  4*IDIG  integer digits, MSD in top nibble.
- `frac_bcd`  out  4*FDIG  fraction digits; first digit after the point is in the top nibble.
- `err`  out  2  00 ok, 01 divide-by-zero, 10 overflow.

## Operation
- **States:**
  - `IDLE`
  - `CALC`
  - `ROUND`, present only with the macro
  - `FIN`
- **IDLE, `start`=1:**
  - If `in_dbz`, set `err`=01 and go to `FIN`. Digits are cleared to 0 and `neg`=0.
  - Otherwise if `in_ovf`, do the same but with `err`=10. `in_dbz` has priority over `in_ovf`.
  - Otherwise latch `sgn`=`val[WIDTH-1]` and `mag`=|`val|` as a WIDTH-bit unsigned value. 0x8000_0000 gives mag 0x8000_0000, i.e. 32768.0.
  - Then clear the BCD accumulators, set counter `i`=0, set `busy`=1 and go to `CALC`.
- **CALC, one iteration per cycle for `WIDTH-FBITS` (16) cycles:**
  - **Integer path:** add 3 to every BCD nibble that is ≥5, then shift left by one, shifting in the next integer bit MSB-first.
  - **Fraction path:** active while `i` < `FDIG`, or `i` < `FDIG`+1 with the macro.
    - Compute frac×10 as a 20-bit value.
    - Append the upper 4 bits as the next digit.
    - Keep the low 16 bits as the new frac.
  - After `i`=15, go to `ROUND` if present, otherwise `FIN`.
- **FIN (one cycle):**
  - Drive the outputs from the accumulators.
  - `neg` = `sgn` AND (any displayed digit nonzero). Negative zero is therefore never shown.
  - Pulse `done`, set `busy`=0, return to `IDLE`.
- **Between conversions:**
  - Outputs hold their values until the next `FIN`.
  - `start` asserted while not in `IDLE` is ignored; there is no queueing.
- **Fraction digits:** truncated unless `Q2D_ROUND_EN` is defined.

## Timing
- **Reset** (any state, including mid-conversion), next edge:
  - State → `IDLE`.
  - `busy`=0, `done`=0, `neg`=0, `int_bcd`=0, `frac_bcd`=0, `err`=00.
  - Internal counter and accumulators cleared.
- **Normal path:** `start` sampled at edge E0.
  - `busy` is high from E0 through the last `CALC` or `ROUND` cycle.
  - Without the macro, `done` and new outputs are visible after E17 (latency 17 cycles).
  - With `ROUND`, latency is 18 cycles.
- **Error path:** `done`, `err` and the cleared digits are visible after E1 (latency 1). `busy` stays 0.
- **`done`:**
  - High for exactly one cycle.
  - `start` may be reasserted in the same cycle `done` is high; it is accepted because the state is already `IDLE` on that edge.
- **`rst` and `start` on the same edge:** `rst` wins and `start` is dropped.

## Configuration
- **Macro:** `Q2D_ROUND_EN`.
- **Defined:**
  - `CALC` produces one extra guard digit (`FDIG`+1 fraction steps).
  - `ROUND` then runs for one cycle: if the guard digit is ≥5, `frac_bcd` and `int_bcd` are incremented as one (`IDIG`+`FDIG`)-digit decimal value with full carry ripple (9999 → 0000 carries into the integer digits).
  - Overflow past `IDIG` digits cannot occur for `WIDTH`=32.
- **Undefined:**
  - No `ROUND` state and no guard digit.
  - Fraction is truncated toward zero in magnitude.

## Test plan
- `val`=0x0001_8000, `start` → after 17 cycles `done`=1, `int_bcd`=0x00001, `frac_bcd`=0x5000, `neg`=0, `err`=00; `busy` high for exactly 16 cycles beforehand.
- `val`=0xFFFE_C000 (−1.25) → `neg`=1, `int_bcd`=0x00001, `frac_bcd`=0x2500.
- `val`=0x7FFF_FFFF → without macro `int_bcd`=0x32767, `frac_bcd`=0x9999; with macro `int_bcd`=0x32768, `frac_bcd`=0x0000, latency 18 cycles.
- `val`=0xFFFF_FFFF → `int_bcd`=0, `frac_bcd`=0, `neg`=0, in both builds.
- `start` with `in_dbz`=1 and `in_ovf`=1 → `done` one cycle later, `err`=01, all digits 0. `start` with only `in_ovf`=1 → `err`=10.
- Second `start` at cycle 5 of a conversion → ignored, first result unchanged. `rst` at cycle 8 → all outputs 0 the next cycle, no `done`; a fresh `start` after that converts normally.

Source files
------------

// File: rtl/q16_to_bcd.sv
// rtl/q16_to_bcd.sv - signed Q16.16 to sign-magnitude BCD converter (optional rounding via Q2D_ROUND_EN)
module q16_to_bcd #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16,
  parameter int IDIG  = 5,
  parameter int FDIG  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    val,
  input  logic                in_dbz,
  input  logic                in_ovf,
  output logic                busy,
  output logic                done,
  output logic                neg,
  output logic [4*IDIG-1:0]   int_bcd,
  output logic [4*FDIG-1:0]   frac_bcd,
  output logic [1:0]          err
);

  localparam int IBITS = WIDTH - FBITS;
  localparam int CW    = $clog2(IBITS + 1);
`ifdef Q2D_ROUND_EN
  // one extra guard digit below the displayed fraction digits
  localparam int FSTEPS = FDIG + 1;
`else
  localparam int FSTEPS = FDIG;
`endif
  localparam int FACC_W = 4 * FSTEPS;
  localparam int DW     = 4 * (IDIG + FDIG);
  localparam logic [CW-1:0]      LAST = CW'(IBITS - 1);
  localparam logic [FBITS+3:0]   TEN  = (FBITS + 4)'(10);

`ifdef Q2D_ROUND_EN
  typedef enum logic [1:0] {IDLE, CALC, ROUND, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
`endif

  state_t state, state_nxt;

  logic [CW-1:0]      i;
  logic               sgn;
  logic [1:0]         err_q;
  logic [IBITS-1:0]   int_sh;
  logic [FBITS-1:0]   frac;
  logic [4*IDIG-1:0]  int_acc;
  logic [FACC_W-1:0]  frac_acc;

  logic [WIDTH-1:0]   mag;
  logic [4*IDIG-1:0]  int_adj;
  logic [4*IDIG-1:0]  int_nxt;
  logic [FBITS+3:0]   frac_prod;
  logic [4*FDIG-1:0]  frac_disp;

  // two's-complement magnitude; the most negative value maps onto itself as unsigned
  assign mag       = val[WIDTH-1] ? (~val + 1'b1) : val;
  assign frac_prod = {4'd0, frac} * TEN;
  assign frac_disp = frac_acc[FACC_W-1 -: 4*FDIG];
  assign int_nxt   = {int_adj[4*IDIG-2:0], int_sh[IBITS-1]};

`ifdef Q2D_ROUND_EN
  assign busy = (state == CALC) || (state == ROUND);

  // increment a packed BCD number by one with full carry ripple
  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    logic          c;
    r = d;
    c = 1'b1;
    for (int k = 0; k < IDIG + FDIG; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
`else
  assign busy = (state == CALC);
`endif

  // double-dabble correction: add 3 to every integer nibble that is 5 or more
  always_comb begin
    int_adj = int_acc;
    for (int k = 0; k < IDIG; k++) begin
      if (int_acc[4*k +: 4] >= 4'd5) begin
        int_adj[4*k +: 4] = int_acc[4*k +: 4] + 4'd3;
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (in_dbz || in_ovf) ? FIN : CALC;
        end
      end
      CALC: begin
        if (i == LAST) begin
`ifdef Q2D_ROUND_EN
          state_nxt = ROUND;
`else
          state_nxt = FIN;
`endif
        end
      end
`ifdef Q2D_ROUND_EN
      ROUND: state_nxt = FIN;
`endif
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: operand capture, per-cycle integer and fraction iteration, output update
  always_ff @(posedge clk) begin
    if (rst) begin
      i        <= '0;
      sgn      <= 1'b0;
      err_q    <= 2'b00;
      int_sh   <= '0;
      frac     <= '0;
      int_acc  <= '0;
      frac_acc <= '0;
      done     <= 1'b0;
      neg      <= 1'b0;
      int_bcd  <= '0;
      frac_bcd <= '0;
      err      <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            int_acc  <= '0;
            frac_acc <= '0;
            i        <= '0;
            if (in_dbz || in_ovf) begin
              err_q  <= in_dbz ? 2'b01 : 2'b10;
              sgn    <= 1'b0;
              int_sh <= '0;
              frac   <= '0;
            end else begin
              err_q  <= 2'b00;
              sgn    <= val[WIDTH-1];
              int_sh <= mag[WIDTH-1:FBITS];
              frac   <= mag[FBITS-1:0];
            end
          end
        end
        CALC: begin
          int_acc <= int_nxt;
          int_sh  <= {int_sh[IBITS-2:0], 1'b0};
          if (int'(i) < FSTEPS) begin
            frac_acc <= {frac_acc[FACC_W-5:0], frac_prod[FBITS+3:FBITS]};
            frac     <= frac_prod[FBITS-1:0];
          end
          i <= i + 1'b1;
        end
`ifdef Q2D_ROUND_EN
        ROUND: begin
          if (frac_acc[3:0] >= 4'd5) begin
            {int_acc, frac_acc[FACC_W-1:4]} <= bcd_inc({int_acc, frac_acc[FACC_W-1:4]});
          end
        end
`endif
        FIN: begin
          int_bcd  <= int_acc;
          frac_bcd <= frac_disp;
          err      <= err_q;
          neg      <= sgn && ((|int_acc) || (|frac_disp));
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
